// File: rtl/sw_scan.sv
// sw_scan: 16-channel switch debouncer with an edge-event stream.
// Define SW_SCAN_FIFO_EN for a 4-entry event FIFO; otherwise events come straight from pending.
module sw_scan #(
  parameter int unsigned TICK_DIV = 500,
  parameter int unsigned STABLE_N = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] sw,
  output logic [15:0] state,
  output logic        evt_valid,
  input  logic        evt_ready,
  output logic [3:0]  evt_idx,
  output logic        evt_rise,
  output logic        overflow
);

  logic [15:0] sync1;
  logic [15:0] sync2;
  logic [31:0] pcnt;
  logic        tick;

  logic [STABLE_N-1:0] hist  [16];
  logic [STABLE_N-1:0] nhist [16];

  logic [15:0] qual;
  logic [15:0] pending;
  logic [15:0] clr;
  logic [3:0]  sel_idx;
  logic        sel_any;
  logic        pop;

  assign tick = (pcnt == 32'(TICK_DIV));
  assign pop  = evt_valid && evt_ready;

  // qual[i] marks a bit whose full history (incl. this sample) disagrees with state
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      nhist[i] = {hist[i][STABLE_N-2:0], sync2[i]};
      qual[i]  = tick &&
                 (((&nhist[i]) && !state[i]) ||
                  ((~|nhist[i]) && state[i]));
    end
  end

  always_comb begin
    sel_any = 1'b0;
    sel_idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (pending[i]) begin
        sel_any = 1'b1;
        sel_idx = 4'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      pcnt  <= '0;
      for (int i = 0; i < 16; i++) hist[i] <= '0;
    end else begin
      sync1 <= sw;
      sync2 <= sync1;
      pcnt  <= tick ? 32'd0 : pcnt + 32'd1;
      if (tick) begin
        for (int i = 0; i < 16; i++) hist[i] <= nhist[i];
      end
    end
  end

  // a requalify while still pending loses the older event
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= '0;
      pending  <= '0;
      overflow <= 1'b0;
    end else begin
      state    <= state ^ qual;
      pending  <= (pending & ~clr) | qual;
      overflow <= overflow | (|(qual & pending & ~clr));
    end
  end

`ifdef SW_SCAN_FIFO_EN
  logic [4:0] mem [4];
  logic [1:0] wptr;
  logic [1:0] rptr;
  logic [2:0] count;
  logic       full;
  logic       push;
  logic [4:0] head;

  assign full = (count == 3'd4);
  assign push = sel_any && (!full || pop);
  assign clr  = push ? (16'd1 << sel_idx) : 16'd0;
  assign head = mem[rptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) mem[i] <= '0;
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= {sel_idx, state[sel_idx]};
        wptr      <= wptr + 2'd1;
      end
      if (pop) rptr <= rptr + 2'd1;
      count <= count + 3'(push) - 3'(pop);
    end
  end

  assign evt_valid = (count != 3'd0);
  assign evt_idx   = evt_valid ? head[4:1] : 4'd0;
  assign evt_rise  = evt_valid && head[0];
`else
  assign clr       = pop ? (16'd1 << sel_idx) : 16'd0;
  assign evt_valid = sel_any;
  assign evt_idx   = sel_idx;
  assign evt_rise  = sel_any && state[sel_idx];
`endif

endmodule
